// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// A miss on a dirty victim writes the victim line back to memory, then refills the line.
module dcache_ctrl #(
   parameter int CACHE_LINE_WIDTH = 128,
   parameter int ADDR_WIDTH       = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int NUM_LINES        = 8,
   parameter int MEM_LATENCY      = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cpu_read,
   input  logic                        cpu_write,
   input  logic [ADDR_WIDTH-1:0]       cpu_addr,
   input  logic [DATA_WIDTH-1:0]       cpu_wdata,
   output logic [DATA_WIDTH-1:0]       cpu_rdata,
   output logic                        cpu_stall,
   output logic                        mem_write,
   output logic [ADDR_WIDTH-3:0]       mem_addr,
   output logic [CACHE_LINE_WIDTH-1:0] mem_wdata,
   input  logic [CACHE_LINE_WIDTH-1:0] mem_rdata
);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = ADDR_WIDTH - 4 - IW;
   localparam int CW = $clog2(MEM_LATENCY) + 1;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t                      state_q;
   logic [CW-1:0]               cnt_q;
   logic [NUM_LINES-1:0]        valid_q, dirty_q;
   logic [TW-1:0]               tag_q  [NUM_LINES];
   logic [CACHE_LINE_WIDTH-1:0] data_q [NUM_LINES];
   logic [TW+IW-1:0]            req_blk_q;
   logic                        mem_write_q;
   logic [ADDR_WIDTH-3:0]       mem_addr_q;
   logic [CACHE_LINE_WIDTH-1:0] mem_wdata_q;
   logic [CACHE_LINE_WIDTH-1:0] line_d;

   logic [1:0]    off;
   logic [IW-1:0] idx, req_idx;
   logic [TW-1:0] tag;
   logic          req, hit, last, unused_ok;

   assign off       = cpu_addr[3:2];
   assign idx       = cpu_addr[4 +: IW];
   assign tag       = cpu_addr[ADDR_WIDTH-1 -: TW];
   assign req       = cpu_read | cpu_write;
   assign hit       = req & valid_q[idx] & (tag_q[idx] == tag);
   assign last      = (cnt_q == CW'(MEM_LATENCY - 1));
   assign req_idx   = req_blk_q[IW-1:0];
   assign unused_ok = ^cpu_addr[1:0];

   // Store data merged into the addressed word of the currently indexed line.
   always_comb begin
      line_d = data_q[idx];
      line_d[off*DATA_WIDTH +: DATA_WIDTH] = cpu_wdata;
   end

   assign cpu_stall = (state_q != IDLE) | (req & ~hit);
   assign cpu_rdata = (state_q == IDLE && cpu_read && !cpu_write && hit) ?
                      data_q[idx][off*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
         req_blk_q   <= '0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  if (cpu_write) begin
                     data_q[idx]  <= line_d;
                     dirty_q[idx] <= 1'b1;
                  end
               end else if (req) begin
                  // The request block is latched so the CPU address is not consulted again until IDLE.
                  cnt_q     <= '0;
                  req_blk_q <= {tag, idx};
                  if (valid_q[idx] && dirty_q[idx]) begin
                     state_q     <= WRITEBACK;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= {2'b00, tag_q[idx], idx};
                     mem_wdata_q <= data_q[idx];
                  end else begin
                     state_q     <= ALLOCATE;
                     mem_write_q <= 1'b0;
                     mem_addr_q  <= {2'b00, tag, idx};
                  end
               end
            end
            WRITEBACK: begin
               if (last) begin
                  state_q     <= ALLOCATE;
                  cnt_q       <= '0;
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= {2'b00, req_blk_q};
                  mem_wdata_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ALLOCATE: begin
               if (last) begin
                  data_q[req_idx]  <= mem_rdata;
                  tag_q[req_idx]   <= req_blk_q[TW+IW-1:IW];
                  valid_q[req_idx] <= 1'b1;
                  dirty_q[req_idx] <= 1'b0;
                  state_q          <= IDLE;
                  cnt_q            <= '0;
                  mem_addr_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q     <= IDLE;
               cnt_q       <= '0;
               mem_write_q <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios then random loads/stores against a transaction-level cache model.
module tb_dcache_ctrl;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_read, cpu_write;
   logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
   logic          cpu_stall, mem_write;
   logic [29:0]   mem_addr;
   logic [127:0]  mem_wdata, mem_rdata;

   logic [127:0]  mem [32];
   logic [31:0]   ref_mem [32][4];
   logic [31:0]   m_line [8][4];
   int            m_tag [8];
   bit            m_valid [8];
   bit            m_dirty [8];
   int            total = 0;
   int            bad = 0;

   dcache_ctrl #(.CACHE_LINE_WIDTH(128), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                 .NUM_LINES(8), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[4:0]];
   always @(posedge clk) if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_stall"}, 128'(cpu_stall), 128'(0));
      chk({tag, "_rdata"}, 128'(cpu_rdata), 128'(0));
      chk({tag, "_mw"},    128'(mem_write), 128'(0));
      chk({tag, "_maddr"}, 128'(mem_addr),  128'(0));
      chk({tag, "_mwd"},   mem_wdata,       128'(0));
   endtask

   // One CPU access; with abort set and a miss predicted, rst is pulsed during the first refill cycle.
   task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input bit abort);
      int blk, idx, t, w, vblk, exp_n, n;
      bit hit, wb, ab;
      logic [127:0] vline;
      logic [31:0] exp_rd;
      blk   = int'(addr[8:4]);
      idx   = blk % 8;
      t     = blk / 8;
      w     = int'(addr[3:2]);
      hit   = m_valid[idx] && m_tag[idx] == t;
      wb    = !hit && m_valid[idx] && m_dirty[idx];
      ab    = abort && !hit;
      vblk  = m_tag[idx] * 8 + idx;
      vline = {m_line[idx][3], m_line[idx][2], m_line[idx][1], m_line[idx][0]};
      exp_n = hit ? 0 : 1 + LAT + (wb ? LAT : 0);
      if (!hit) begin
         for (int k = 0; k < 4; k++) begin
            if (wb) ref_mem[vblk][k] = m_line[idx][k];
            m_line[idx][k] = ref_mem[blk][k];
         end
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = t;
      end
      exp_rd = 32'h0;
      if (!ab) begin
         if (wr) begin
            m_line[idx][w] = wd;
            m_dirty[idx]   = 1'b1;
         end else begin
            exp_rd = m_line[idx][w];
         end
      end

      @(negedge clk);
      cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
      #1;
      n = 0;
      while (cpu_stall && n < 40) begin
         if (n == 0) begin
            chk("miss_idle_mw", 128'(mem_write), 128'(0));
            chk("miss_idle_maddr", 128'(mem_addr), 128'(0));
         end else if (wb && n <= LAT) begin
            chk("wb_mw", 128'(mem_write), 128'(1));
            chk("wb_maddr", 128'(mem_addr), 128'(vblk));
            chk("wb_mwd", mem_wdata, vline);
         end else if (n < exp_n) begin
            chk("al_mw", 128'(mem_write), 128'(0));
            chk("al_maddr", 128'(mem_addr), 128'(blk));
         end
         if (ab && n == 1 + (wb ? LAT : 0)) break;
         @(posedge clk); @(negedge clk); #1;
         n++;
      end

      if (ab) begin
         rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
         @(posedge clk); @(negedge clk);
         rst = 1'b0;
         #1;
         idle_chk("post_rst");
         for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0;
            m_dirty[k] = 1'b0;
         end
      end else begin
         chk("stall_cycles", 128'(n), 128'(exp_n));
         chk(wr ? "rdata_on_write" : "rdata", 128'(cpu_rdata), 128'(exp_rd));
         @(posedge clk); @(negedge clk);
         cpu_read = 1'b0; cpu_write = 1'b0;
         #1;
         idle_chk("idle");
      end
   endtask

   initial begin
      rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      for (int b = 0; b < 32; b++)
         for (int k = 0; k < 4; k++) ref_mem[b][k] = 32'h0;
      ref_mem[0][0] = 32'h3;
      ref_mem[0][2] = 32'hF0;
      ref_mem[2][0] = 32'h2C;
      ref_mem[8][0] = 32'h4;
      for (int b = 0; b < 32; b++)
         mem[b] = {ref_mem[b][3], ref_mem[b][2], ref_mem[b][1], ref_mem[b][0]};
      for (int k = 0; k < 8; k++) begin
         m_valid[k] = 1'b0; m_dirty[k] = 1'b0; m_tag[k] = 0;
         for (int j = 0; j < 4; j++) m_line[k][j] = 32'h0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      idle_chk("reset");

      do_req(1, 0, 32'h00, 32'h0, 0);
      do_req(1, 0, 32'h08, 32'h0, 0);
      do_req(0, 1, 32'h04, 32'hDEADBEEF, 0);
      do_req(1, 0, 32'h04, 32'h0, 0);
      do_req(1, 0, 32'h80, 32'h0, 0);
      do_req(0, 1, 32'h24, 32'h55, 0);
      do_req(1, 0, 32'h24, 32'h0, 0);
      do_req(1, 0, 32'h20, 32'h0, 0);
      do_req(1, 1, 32'h28, 32'h1234, 0);
      do_req(1, 0, 32'h28, 32'h0, 0);
      do_req(1, 0, 32'h00, 32'h0, 0);
      do_req(1, 0, 32'h80, 32'h0, 1);
      do_req(1, 0, 32'h80, 32'h0, 0);
      do_req(1, 0, 32'h24, 32'h0, 0);

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         int op;
         a  = 32'($urandom_range(0, 127)) << 2;
         op = $urandom_range(0, 9);
         do_req(op < 5 || op == 9, op >= 5, a, $urandom, $urandom_range(0, 24) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
